piso_shift_controller: RTL and testbench



---
 rtl/piso_shift_controller_pkg.sv | 19 +
 rtl/piso_shift_controller_if.sv | 28 ++
 rtl/piso_shift_reg.sv | 46 ++++
 rtl/piso_shift_controller.sv | 99 +++++++++
 tb/tb_piso_shift_controller.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_shift_controller_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | piso_pkg : shared state encoding and sizing helper for the PISO |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_shift_controller_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | piso_shift_controller_if : producer/consumer bundle of the PISO |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface piso_shift_controller_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             shift_en;
  logic             abort;
  logic             ser_out;
  logic             frame;
  logic             done;

  modport master (
    output in_data, in_valid, shift_en, abort,
    input  in_ready, ser_out, frame, done
  );

  modport slave (
    input  in_data, in_valid, shift_en, abort,
    output in_ready, ser_out, frame, done
  );
endinterface
`default_nettype wire

// File: rtl/piso_shift_reg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | piso_shift_reg : loadable zero-filling shift register           |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  wire logic             clock,
  input  wire logic             reset_n,
  input  wire logic             load,
  input  wire logic             shift,
  input  wire logic             clear,
  input  wire logic [WIDTH-1:0] din,
  output logic                  sout
);

  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_shifted;

  // Output end is bit 0 when LSB first, bit WIDTH-1 otherwise.
  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign w_shifted = {1'b0, r_sreg[WIDTH-1:1]};
      assign sout      = r_sreg[0];
    end else begin : g_msb_first
      assign w_shifted = {r_sreg[WIDTH-2:0], 1'b0};
      assign sout      = r_sreg[WIDTH-1];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sreg <= '0;
    end else if (clear) begin
      r_sreg <= '0;
    end else if (load) begin
      r_sreg <= din;
    end else if (shift) begin
      r_sreg <= w_shifted;
    end
  end

endmodule
`default_nettype wire

// File: rtl/piso_shift_controller.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | piso_shift_controller : handshake-loaded serializer sequencer   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module piso_shift_controller
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input wire logic                clock,
  input wire logic                reset_n,
  piso_shift_controller_if.slave  bus
);

  localparam int c_CNT_W = cnt_width(WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               w_load;
  logic               w_shift;
  logic               w_clear;
  logic               w_sout;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // abort outranks everything, including acceptance while idle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid && !bus.abort) begin
          w_load      = 1'b1;
          w_cnt_nxt   = c_CNT_W'(WIDTH - 1);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          w_clear     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (bus.shift_en) begin
          if (r_cnt != '0) begin
            w_shift   = 1'b1;
            w_cnt_nxt = r_cnt - 1'b1;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (bus.abort) begin
          w_clear   = 1'b1;
          w_cnt_nxt = '0;
        end
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_sreg (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (w_load),
    .shift   (w_shift),
    .clear   (w_clear),
    .din     (bus.in_data),
    .sout    (w_sout)
  );

  assign bus.in_ready = (r_state == IDLE);
  assign bus.frame    = (r_state == SHIFT);
  assign bus.done     = (r_state == DONE);
  assign bus.ser_out  = (r_state == SHIFT) ? w_sout : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_controller.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_piso_shift_controller : MSB- and LSB-first DUTs vs word model |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_piso_shift_controller;

  localparam int W = 8;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] t_data  = '0;
  logic         t_valid = 1'b0;
  logic         t_shen  = 1'b0;
  logic         t_abort = 1'b0;

  always #5 clock = ~clock;

  piso_shift_controller_if #(.WIDTH(W)) if_m ();
  piso_shift_controller_if #(.WIDTH(W)) if_l ();

  assign if_m.in_data  = t_data;
  assign if_m.in_valid = t_valid;
  assign if_m.shift_en = t_shen;
  assign if_m.abort    = t_abort;
  assign if_l.in_data  = t_data;
  assign if_l.in_valid = t_valid;
  assign if_l.shift_en = t_shen;
  assign if_l.abort    = t_abort;

  piso_shift_controller #(.WIDTH(W), .LSB_FIRST(0)) dut_m (
    .clock (clock), .reset_n (reset_n), .bus (if_m)
  );
  piso_shift_controller #(.WIDTH(W), .LSB_FIRST(1)) dut_l (
    .clock (clock), .reset_n (reset_n), .bus (if_l)
  );

  // Word-level model: the accepted word plus how many bits were consumed.
  bit           m_active, m_done;
  int           m_k;
  logic [W-1:0] m_word;

  int tests = 0;
  int fails = 0;

  logic s_ser_m, s_ser_l, s_frame, s_done, s_ready;
  logic hist_m [0:63];

  function automatic logic m_bit(input bit lsb);
    if (!m_active) return 1'b0;
    return lsb ? m_word[m_k] : m_word[W-1-m_k];
  endfunction

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic model_reset();
    m_active = 0; m_done = 0; m_k = 0; m_word = '0;
  endtask

  task automatic model_edge();
    if (t_abort && (m_active || m_done)) begin
      model_reset();
    end else if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      if (t_shen) begin
        if (m_k == W - 1) begin
          m_active = 0;
          m_done   = 1;
        end else begin
          m_k++;
        end
      end
    end else if (t_valid && !t_abort) begin
      m_word = t_data; m_k = 0; m_active = 1;
    end
  endtask

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] em, el, om, ol;
    em = {!m_active && !m_done, m_active, m_done, m_bit(0)};
    el = {!m_active && !m_done, m_active, m_done, m_bit(1)};
    om = {if_m.in_ready, if_m.frame, if_m.done, if_m.ser_out};
    ol = {if_l.in_ready, if_l.frame, if_l.done, if_l.ser_out};
    tests++;
    assert (om === em) else begin
      fails++;
      $error("FAIL %s msb rdy/frm/done/ser observed=%b expected=%b", tag, om, em);
    end
    tests++;
    assert (ol === el) else begin
      fails++;
      $error("FAIL %s lsb rdy/frm/done/ser observed=%b expected=%b", tag, ol, el);
    end
  endtask

  // Sample mid-cycle, then let one rising edge act on the current inputs.
  task automatic step(input string tag);
    @(negedge clock);
    check_all(tag);
    s_ser_m = if_m.ser_out; s_ser_l = if_l.ser_out;
    s_frame = if_m.frame;   s_done  = if_m.done;  s_ready = if_m.in_ready;
    @(posedge clock);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] d, input int st_lo, input int st_hi,
                           output logic [W-1:0] sm, output logic [W-1:0] sl,
                           output int dcyc);
    t_data = d; t_valid = 1'b1; t_shen = 1'b1; t_abort = 1'b0;
    step("accept");
    t_valid = 1'b0; sm = '0; sl = '0; dcyc = -1;
    for (int i = 1; i <= 40 && dcyc < 0; i++) begin
      t_shen = !(i >= st_lo && i <= st_hi);
      step("word");
      hist_m[i] = s_ser_m;
      if (s_frame && t_shen) begin
        sm = {sm[W-2:0], s_ser_m};
        sl = {sl[W-2:0], s_ser_l};
      end
      if (s_done) dcyc = i;
    end
    t_shen = 1'b1;
    step("ready_after");
    expect_eq("ready_after_done", s_ready, 1'b1);
  endtask

  initial begin
    logic [W-1:0] sm, sl;
    logic [15:0]  bm, bl;
    int           dcyc, acc2, nbits, gaps;
    logic         any_done;

    model_reset();
    step("reset");
    step("reset");
    reset_n = 1'b1;
    step("idle");

    // nominal, both bit orders
    send_word(8'hC4, 0, -1, sm, sl, dcyc);
    expect_eq("nominal_msb_stream", sm, 8'hC4);
    expect_eq("nominal_lsb_stream", sl, 8'h23);
    expect_eq("nominal_done_cycle", dcyc, 9);

    // stall on cycles 3-4
    send_word(8'hC4, 3, 4, sm, sl, dcyc);
    expect_eq("stall_msb_stream", sm, 8'hC4);
    expect_eq("stall_lsb_stream", sl, 8'h23);
    expect_eq("stall_done_cycle", dcyc, 11);
    expect_eq("stall_hold_c3", hist_m[3], 1'b0);
    expect_eq("stall_hold_c4", hist_m[4], 1'b0);
    expect_eq("stall_hold_c5", hist_m[5], 1'b0);

    // abort in cycle 4
    t_data = 8'hFF; t_valid = 1'b1; t_shen = 1'b1;
    step("abort_accept");
    t_valid = 1'b0; any_done = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step("abort_pre");
      any_done |= s_done;
    end
    t_abort = 1'b1;
    step("abort_cyc4");
    t_abort = 1'b0;
    step("abort_cyc5");
    expect_eq("abort_frame", s_frame, 1'b0);
    expect_eq("abort_ser", s_ser_m, 1'b0);
    expect_eq("abort_ready", s_ready, 1'b1);
    any_done |= s_done;
    step("abort_after");
    any_done |= s_done;
    expect_eq("abort_no_done", any_done, 1'b0);
    send_word(8'h01, 0, -1, sm, sl, dcyc);
    expect_eq("post_abort_msb", sm, 8'h01);
    expect_eq("post_abort_lsb", sl, 8'h80);

    // asynchronous reset in cycle 3
    t_data = 8'hAA; t_valid = 1'b1;
    step("rst_accept");
    t_valid = 1'b0;
    step("rst_c1");
    step("rst_c2");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    expect_eq("rst_async_ready", if_m.in_ready, 1'b1);
    expect_eq("rst_async_frame", if_l.frame, 1'b0);
    step("in_reset");
    step("in_reset");
    reset_n = 1'b1;
    step("rst_release");
    send_word(8'h96, 0, -1, sm, sl, dcyc);
    expect_eq("post_rst_msb", sm, 8'h96);
    expect_eq("post_rst_lsb", sl, rev(8'h96));

    // back-to-back with in_valid held high
    t_data = 8'h0F; t_valid = 1'b1; t_shen = 1'b1;
    step("b2b_accept");
    t_data = 8'hF0; acc2 = -1; nbits = 0; gaps = 0; bm = '0; bl = '0;
    for (int i = 1; i <= 20; i++) begin
      t_valid = (i <= 18);
      step("b2b");
      if (s_ready && acc2 < 0) acc2 = i;
      if (s_frame) begin
        bm = {bm[14:0], s_ser_m};
        bl = {bl[14:0], s_ser_l};
        nbits++;
      end else if (nbits > 0 && nbits < 16) begin
        gaps++;
      end
    end
    t_valid = 1'b0;
    expect_eq("b2b_second_accept", acc2, 10);
    expect_eq("b2b_msb_stream", bm, 16'h0FF0);
    expect_eq("b2b_lsb_stream", bl, 16'hF00F);
    expect_eq("b2b_gap_cycles", gaps, 2);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      t_data  = W'($urandom);
      t_valid = ($urandom_range(0, 1) == 1);
      t_abort = ($urandom_range(0, 15) == 0);
      t_shen  = ($urandom_range(0, 3) != 0);
      step("random");
    end
    t_valid = 1'b0; t_abort = 1'b0; t_shen = 1'b1;
    for (int n = 0; n < 12; n++) step("drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
